reg_file_p: RTL and testbench



---
 rtl/reg_file_pkg.sv | 15 +
 rtl/reg_file_rd_port.sv | 36 +++
 rtl/reg_file_p.sv | 120 ++++++++++++
 tb/tb_reg_file_p.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared types and default sizes for the parametrised register file.
// Optional feature macro: REG_FILE_BYPASS_EN (write-to-read forwarding).
package reg_file_pkg;

    // Bulk-clear sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_e;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_DEPTH = 4;

endpackage

// File: rtl/reg_file_rd_port.sv
// One combinational read port: DEPTH:1 mux over the flat register bus.
// With REG_FILE_BYPASS_EN defined, a write accepted this cycle to the
// selected register is forwarded straight from the write data.
module reg_file_rd_port
    import reg_file_pkg::*;
#(
    parameter  int WIDTH  = DEF_WIDTH,
    parameter  int DEPTH  = DEF_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    output logic [WIDTH-1:0]       rd_o,
    input  logic [DEPTH*WIDTH-1:0] regs_i,
    input  logic [ADDR_W-1:0]      sel_i
`ifdef REG_FILE_BYPASS_EN
   ,input  logic                   byp_en_i,
    input  logic [ADDR_W-1:0]      sel_w_i,
    input  logic [WIDTH-1:0]       data_i
`endif
);

    // Select the addressed register, then let a same-cycle write override it
    always_comb begin
        rd_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_i == ADDR_W'(i)) begin
                rd_o = regs_i[i*WIDTH +: WIDTH];
            end
        end
`ifdef REG_FILE_BYPASS_EN
        if (byp_en_i && (sel_w_i == sel_i)) begin
            rd_o = data_i;
        end
`endif
    end

endmodule

// File: rtl/reg_file_p.sv
// Parametrised WIDTH x DEPTH register file: two combinational read ports,
// one synchronous write port, and a bulk-clear sequencer that zeroes one
// register per cycle while blocking writes.
// Optional feature macro: REG_FILE_BYPASS_EN (write-to-read forwarding).
module reg_file_p
    import reg_file_pkg::*;
#(
    parameter  int WIDTH  = DEF_WIDTH,
    parameter  int DEPTH  = DEF_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ADDR_W-1:0]      sel_a,
    input  logic [ADDR_W-1:0]      sel_b,
    output logic [WIDTH-1:0]       out_a,
    output logic [WIDTH-1:0]       out_b,
    input  logic                   write_en,
    input  logic [ADDR_W-1:0]      sel_w,
    input  logic [WIDTH-1:0]       data_in,
    input  logic                   clr_req,
    output logic                   clr_busy,
    output logic                   clr_done,
    output logic                   wr_drop,
    output logic [DEPTH*WIDTH-1:0] q_all
);

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] clrCnt_q, clrCnt_d;
    logic              wrDrop_q, wrDrop_d;
    logic [WIDTH-1:0]  regs_q [DEPTH];
    logic              wrAccept;

    assign wrAccept = write_en && (state_q == IDLE);

    // Flatten storage onto the debug bus, register i at [i*WIDTH +: WIDTH]
    for (genvar g = 0; g < DEPTH; g++) begin : gen_flat
        assign q_all[g*WIDTH +: WIDTH] = regs_q[g];
    end

    // Sequencer next state, clear counter and write-rejection flag
    always_comb begin
        state_d  = state_q;
        clrCnt_d = clrCnt_q;
        wrDrop_d = write_en && (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d  = CLEAR;
                    clrCnt_d = '0;
                end
            end
            CLEAR: begin
                clrCnt_d = clrCnt_q + 1'b1;
                if (clrCnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state, counter and drop flag; reset aborts any clear in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            clrCnt_q <= '0;
            wrDrop_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            clrCnt_q <= clrCnt_d;
            wrDrop_q <= wrDrop_d;
        end
    end

    // Storage: clearing takes priority, writes only land while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (state_q == CLEAR) begin
            regs_q[clrCnt_q] <= '0;
        end else if (wrAccept) begin
            regs_q[sel_w] <= data_in;
        end
    end

    assign clr_busy = (state_q == CLEAR);
    assign clr_done = (state_q == DONE);
    assign wr_drop  = wrDrop_q;

    reg_file_rd_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rd_a (
        .rd_o     (out_a),
        .regs_i   (q_all),
        .sel_i    (sel_a)
`ifdef REG_FILE_BYPASS_EN
       ,.byp_en_i (wrAccept),
        .sel_w_i  (sel_w),
        .data_i   (data_in)
`endif
    );

    reg_file_rd_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rd_b (
        .rd_o     (out_b),
        .regs_i   (q_all),
        .sel_i    (sel_b)
`ifdef REG_FILE_BYPASS_EN
       ,.byp_en_i (wrAccept),
        .sel_w_i  (sel_w),
        .data_i   (data_in)
`endif
    );

endmodule

// File: tb/tb_reg_file_p.sv
// Self-checking bench for reg_file_p: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against an
// array-based model of the register file.
module tb_reg_file_p;

    localparam int W   = 4;
    localparam int D   = 4;
    localparam int AW  = 2;
    localparam int W2  = 8;
    localparam int D2  = 16;
    localparam int AW2 = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [AW-1:0]   sel_a, sel_b, sel_w;
    logic [W-1:0]    out_a, out_b, data_in;
    logic            write_en, clr_req, clr_busy, clr_done, wr_drop;
    logic [D*W-1:0]  q_all;

    logic [AW2-1:0]  sel_a16, sel_b16, sel_w16;
    logic [W2-1:0]   out_a16, out_b16, data_in16;
    logic            write_en16, clr_req16, clr_busy16, clr_done16, wr_drop16;
    logic [D2*W2-1:0] q_all16;

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    reg_file_p #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .sel_a(sel_a), .sel_b(sel_b),
        .out_a(out_a), .out_b(out_b), .write_en(write_en), .sel_w(sel_w),
        .data_in(data_in), .clr_req(clr_req), .clr_busy(clr_busy),
        .clr_done(clr_done), .wr_drop(wr_drop), .q_all(q_all)
    );

    reg_file_p #(.WIDTH(W2), .DEPTH(D2)) dut16 (
        .clk(clk), .rst_n(rst_n), .sel_a(sel_a16), .sel_b(sel_b16),
        .out_a(out_a16), .out_b(out_b16), .write_en(write_en16), .sel_w(sel_w16),
        .data_in(data_in16), .clr_req(clr_req16), .clr_busy(clr_busy16),
        .clr_done(clr_done16), .wr_drop(wr_drop16), .q_all(q_all16)
    );

    // Behavioural model: mode 0 idle, 1 clearing, 2 clear finished
    logic [W-1:0] mem [D];
    int           mode;
    int           clrIdx;
    bit           mDrop;
    bit           mAcc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < D; i++) mem[i] = '0;
            mode   = 0;
            clrIdx = 0;
            mDrop  = 1'b0;
        end else begin
            mAcc  = write_en && (mode == 0);
            mDrop = write_en && (mode != 0);
            if (mode == 0) begin
                if (mAcc) mem[sel_w] = data_in;
                if (clr_req) begin
                    mode   = 1;
                    clrIdx = 0;
                end
            end else if (mode == 1) begin
                mem[clrIdx] = '0;
                clrIdx++;
                if (clrIdx == D) mode = 2;
            end else begin
                mode = 0;
            end
        end
    end

    function automatic logic [W-1:0] mdlRead(logic [AW-1:0] s);
`ifdef REG_FILE_BYPASS_EN
        if (write_en && (mode == 0) && (sel_w == s)) return data_in;
`endif
        return mem[s];
    endfunction

    function automatic logic [D*W-1:0] mdlFlat();
        logic [D*W-1:0] f;
        for (int i = 0; i < D; i++) f[i*W +: W] = mem[i];
        return f;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act,
                               input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, mid-cycle away from the edge
    always @(negedge clk) begin
        if (checking) begin
            checkOutput("cyc_out_a", out_a, mdlRead(sel_a));
            checkOutput("cyc_out_b", out_b, mdlRead(sel_b));
            checkOutput("cyc_q_all", q_all, mdlFlat());
            checkOutput("cyc_busy", clr_busy, mode == 1);
            checkOutput("cyc_done", clr_done, mode == 2);
            checkOutput("cyc_drop", wr_drop, mDrop);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic we, input logic [AW-1:0] sw,
                                 input logic [W-1:0] din, input logic [AW-1:0] sa,
                                 input logic [AW-1:0] sb, input logic cr);
        write_en = we;
        sel_w    = sw;
        data_in  = din;
        sel_a    = sa;
        sel_b    = sb;
        clr_req  = cr;
    endtask

    task automatic doWrite(input logic [AW-1:0] sw, input logic [W-1:0] din);
        applyStimulus(1'b1, sw, din, sel_a, sel_b, 1'b0);
        tick();
        write_en = 1'b0;
    endtask

    logic [D*W-1:0] qExp [4];
    int n;

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, '0, '0, '0, '0, 1'b0);
        write_en16 = 1'b0; clr_req16 = 1'b0; sel_w16 = '0; data_in16 = '0;
        sel_a16 = '0; sel_b16 = '0;
        #12;
        checkOutput("reset_q_all", q_all, '0);
        checkOutput("reset_busy", clr_busy, 1'b0);
        checkOutput("reset_out_a", out_a, '0);
        checkOutput("reset_q_all16", q_all16, '0);
        #1 rst_n = 1'b1;
        tick();
        checking = 1'b1;

        // Basic write / read, including both ports on one register
        doWrite(2'd2, 4'hA);
        doWrite(2'd1, 4'h5);
        applyStimulus(1'b0, '0, '0, 2'd2, 2'd1, 1'b0);
        #3;
        checkOutput("rd_a_r2", out_a, 4'hA);
        checkOutput("rd_b_r1", out_b, 4'h5);
        sel_b = 2'd2;
        #1;
        checkOutput("same_sel_a", out_a, 4'hA);
        checkOutput("same_sel_b", out_b, 4'hA);
        tick();

        // Bulk clear from all-ones, with a rejected write in the first clear cycle
        for (int i = 0; i < D; i++) doWrite(AW'(i), 4'hF);
        qExp[0] = 16'hFFFF; qExp[1] = 16'hFFF0; qExp[2] = 16'hFF00; qExp[3] = 16'hF000;
        applyStimulus(1'b0, '0, '0, 2'd0, 2'd3, 1'b1);
        tick();
        applyStimulus(1'b1, 2'd3, 4'h5, 2'd0, 2'd3, 1'b0);
        for (int c = 0; c < 4; c++) begin
            #3;
            checkOutput("clr_q_all", q_all, qExp[c]);
            checkOutput("clr_busy", clr_busy, 1'b1);
            checkOutput("clr_drop", wr_drop, c == 1);
            tick();
            write_en = 1'b0;
        end
        #3;
        checkOutput("clr_end_q_all", q_all, '0);
        checkOutput("clr_done_pulse", clr_done, 1'b1);
        checkOutput("clr_done_busy", clr_busy, 1'b0);
        tick();
        #3;
        checkOutput("clr_done_low", clr_done, 1'b0);
        tick();

        // Asynchronous reset two cycles into a clear
        doWrite(2'd3, 4'h9);
        doWrite(2'd2, 4'h9);
        applyStimulus(1'b0, '0, '0, 2'd3, 2'd2, 1'b1);
        tick();
        clr_req = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_q_all", q_all, '0);
        checkOutput("midrst_busy", clr_busy, 1'b0);
        checkOutput("midrst_out_a", out_a, '0);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            #3;
            checkOutput("midrst_no_done", clr_done, 1'b0);
        end
        tick();
        doWrite(2'd1, 4'h6);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        n = 0;
        #3;
        while (clr_busy === 1'b1 && n < 20) begin
            n++;
            tick();
            #3;
        end
        checkOutput("reclear_cycles", n, 4);
        checkOutput("reclear_done", clr_done, 1'b1);
        checkOutput("reclear_q_all", q_all, '0);
        tick();

        // Same-cycle read of a register being written
        doWrite(2'd3, 4'h2);
        applyStimulus(1'b1, 2'd3, 4'h7, 2'd3, 2'd0, 1'b0);
        #3;
`ifdef REG_FILE_BYPASS_EN
        checkOutput("bypass_pre", out_a, 4'h7);
`else
        checkOutput("bypass_pre", out_a, 4'h2);
`endif
        tick();
        write_en = 1'b0;
        #3;
        checkOutput("bypass_post", out_a, 4'h7);
        tick();

        // Wider, deeper instance: top register write and 16-cycle clear
        write_en16 = 1'b1; sel_w16 = 4'd15; data_in16 = 8'hC3; sel_a16 = 4'd15;
        tick();
        write_en16 = 1'b0;
        #3;
        checkOutput("p16_rd", out_a16, 8'hC3);
        checkOutput("p16_q_top", q_all16[127:120], 8'hC3);
        clr_req16 = 1'b1;
        tick();
        clr_req16 = 1'b0;
        n = 0;
        #3;
        while (clr_busy16 === 1'b1 && n < 40) begin
            n++;
            tick();
            #3;
        end
        checkOutput("p16_clear_cycles", n, 16);
        checkOutput("p16_done", clr_done16, 1'b1);
        checkOutput("p16_q_all", q_all16, '0);
        tick();

        // Randomized traffic against the model
        for (int c = 0; c < 500; c++) begin
            applyStimulus(1'($urandom_range(0, 1)), AW'($urandom), W'($urandom),
                          AW'($urandom), AW'($urandom), $urandom_range(0, 19) == 0);
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            tick();
        end

        checking = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
